// File: rtl/bg_layer_gen.sv
// Background layer generator: classifies each pixel as sky, textured band or ground and
// unpacks band texels from a packed sync ROM, emitting {palette, colour} 3 clocks after pixel_tick.
module bg_layer_gen #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int BPP = 3,
  parameter int PPW = 3,
  parameter int PAL_W = 5,
  parameter int COL_AW = 4,
  parameter int ROW_AW = 7,
  parameter int TOP_RST = 300,
  parameter int BOT_RST = 428,
  parameter logic [3:0] SKY_IDX = 4'h5,
  parameter logic [3:0] GND_IDX = 4'h7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixel_tick,
  input  logic                     frame_start,
  input  logic [XW-1:0]            x,
  input  logic [YW-1:0]            y,
  input  logic                     mem_enable,
  input  logic                     mem_write,
  input  logic [2:0]               reg_sel,
  input  logic [15:0]              write_data,
  output logic [ROW_AW+COL_AW-1:0] rom_addr,
  input  logic [BPP*PPW-1:0]       rom_data,
  output logic [PAL_W+3:0]         index_out,
  output logic                     index_valid
);

  localparam int PH_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int DW = BPP * PPW;

  typedef enum logic [1:0] {REG_SKY, REG_BAND, REG_GND} region_t;

  logic [PAL_W-1:0]  palette;
  logic [15:0]       sx_pend, sx_live;
  logic [ROW_AW-1:0] sy_pend, sy_live;
  logic [YW-1:0]     band_top, band_bot;

  logic [PH_W-1:0]   phase;
  logic [COL_AW-1:0] word;

  logic [PH_W-1:0]   s1_phase, s2_phase;
  region_t           s1_region, s2_region;
  logic              s1_valid, s2_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      palette  <= '0;
      sx_pend  <= '0;
      sx_live  <= '0;
      sy_pend  <= '0;
      sy_live  <= '0;
      band_top <= YW'(TOP_RST);
      band_bot <= YW'(BOT_RST);
    end else begin
      // Live scroll takes the pending value as it stood before any write in this same clock.
      if (frame_start) begin
        sx_live <= sx_pend;
        sy_live <= sy_pend;
      end
      if (mem_enable && mem_write) begin
        case (reg_sel)
          3'd0: palette  <= write_data[PAL_W-1:0];
          3'd1: sx_pend  <= write_data;
          3'd2: sy_pend  <= write_data[ROW_AW-1:0];
          3'd3: band_top <= write_data[YW-1:0];
          3'd4: band_bot <= write_data[YW-1:0];
          default: ;
        endcase
      end
    end
  end

  logic [COL_AW-1:0] coarse;
  logic [7:0]        fine;
  logic [PH_W-1:0]   fine_phase, cur_phase, next_phase;
  logic [COL_AW-1:0] cur_word, next_word;
  logic [ROW_AW-1:0] row;
  region_t           region;
  logic              unused_hi;

  assign coarse    = sx_live[8 +: COL_AW];
  assign fine      = sx_live[7:0];
  assign unused_hi = &{1'b0, sx_live[15:8+COL_AW], write_data[15:8+COL_AW]};

  always_comb begin
    fine_phase = (int'(fine) >= PPW - 1) ? PH_W'(PPW - 1) : PH_W'(fine);
    cur_phase  = (x == '0) ? fine_phase : phase;
    cur_word   = (x == '0) ? coarse : word;
    if (cur_phase == PH_W'(PPW - 1)) begin
      next_phase = '0;
      next_word  = cur_word + 1'b1;
    end else begin
      next_phase = cur_phase + 1'b1;
      next_word  = cur_word;
    end
    // An empty or inverted band falls through to ground for every y >= band_top.
    if (y < band_top)      region = REG_SKY;
    else if (y < band_bot) region = REG_BAND;
    else                   region = REG_GND;
    row = ROW_AW'(y) - ROW_AW'(band_top) + sy_live;
  end

  logic [DW-1:0]  shifted;
  logic [BPP-1:0] field;
  logic [3:0]     colour;

  always_comb begin
    shifted = rom_data >> (BPP * (PPW - 1 - int'(s2_phase)));
    field   = shifted[BPP-1:0];
    case (s2_region)
      REG_SKY:  colour = SKY_IDX;
      REG_BAND: colour = 4'(field);
      default:  colour = GND_IDX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase       <= '0;
      word        <= '0;
      rom_addr    <= '0;
      s1_phase    <= '0;
      s1_region   <= REG_SKY;
      s1_valid    <= 1'b0;
      s2_phase    <= '0;
      s2_region   <= REG_SKY;
      s2_valid    <= 1'b0;
      index_out   <= '0;
      index_valid <= 1'b0;
    end else begin
      s1_valid <= pixel_tick;
      if (pixel_tick) begin
        rom_addr  <= {row, cur_word};
        s1_phase  <= cur_phase;
        s1_region <= region;
        phase     <= next_phase;
        word      <= next_word;
      end
      // The ROM reads rom_addr on this edge, so its word lines up with s2 metadata.
      s2_valid    <= s1_valid;
      s2_phase    <= s1_phase;
      s2_region   <= s1_region;
      index_valid <= s2_valid;
      if (s2_valid) index_out <= {palette, colour};
    end
  end

endmodule

// File: tb/tb_bg_layer_gen.sv
// Bench for bg_layer_gen: directed scenarios then random traffic, checked against a
// linear-position model of the texture scan and an expected-index queue.
module tb_bg_layer_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        mem_enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  reg_sel = '0;
  logic [15:0] write_data = '0;
  logic [10:0] rom_addr;
  logic [8:0]  rom_data = '0;
  logic [8:0]  index_out;
  logic        index_valid;

  bg_layer_gen dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .frame_start(frame_start),
    .x(x), .y(y), .mem_enable(mem_enable), .mem_write(mem_write),
    .reg_sel(reg_sel), .write_data(write_data), .rom_addr(rom_addr),
    .rom_data(rom_data), .index_out(index_out), .index_valid(index_valid)
  );

  always #5 clk = ~clk;

  logic [8:0] rom_mem [0:2047];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  int         exp_c[$];

  // Model state: registers plus a linear texel position along the scanline.
  int m_pal, m_sx_p, m_sy_p, m_sx, m_sy, m_top, m_bot, m_pos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pal = 0; m_sx_p = 0; m_sy_p = 0; m_sx = 0; m_sy = 0;
    m_top = 300; m_bot = 428; m_pos = 0;
    exp_q.delete();
    exp_c.delete();
  endtask

  always @(negedge clk) begin
    logic exp_valid;
    if (rst) begin
      exp_valid = (exp_c.size() != 0) && (exp_c[0] == cyc);
      if (index_valid || exp_valid) chk("valid", index_valid, exp_valid);
      if (index_valid && exp_valid) chk("index", index_out, exp_q[0]);
      if (exp_valid) begin
        void'(exp_q.pop_front());
        void'(exp_c.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic commit();
    m_sx = m_sx_p;
    m_sy = m_sy_p;
  endtask

  task automatic wr(input int sel, input int data, input bit fs);
    mem_enable = 1'b1; mem_write = 1'b1; reg_sel = sel[2:0];
    write_data = data[15:0]; frame_start = fs;
    if (fs) commit();
    case (sel)
      0: m_pal = data & 31;
      1: m_sx_p = data & 16'hffff;
      2: m_sy_p = data & 127;
      3: m_top = data & 1023;
      4: m_bot = data & 1023;
      default: ;
    endcase
    step();
    mem_enable = 1'b0; mem_write = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    commit();
    step();
    frame_start = 1'b0;
  endtask

  task automatic tick(input int xx, input int yy);
    int ph, wd, row, addr, ci, fine;
    if (xx == 0) begin
      fine = m_sx & 255;
      m_pos = ((m_sx >> 8) & 15) * 3 + ((fine > 2) ? 2 : fine);
    end
    ph = m_pos % 3;
    wd = (m_pos / 3) % 16;
    m_pos = (m_pos + 1) % 48;
    row = (((yy - m_top + m_sy) % 128) + 128) % 128;
    addr = row * 16 + wd;
    if (yy < m_top) ci = 5;
    else if (yy < m_bot) ci = (int'(rom_mem[addr]) >> (3 * (2 - ph))) & 7;
    else ci = 7;
    exp_q.push_back(9'((m_pal << 4) | ci));
    exp_c.push_back(cyc + 3);
    pixel_tick = 1'b1; x = xx[9:0]; y = yy[9:0];
    step();
    pixel_tick = 1'b0;
    chk("rom_addr", rom_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 9'($urandom_range(0, 511));
    rom_mem[0] = 9'o123;
    rom_mem[1] = 9'o456;
    model_reset();

    // Reset held 3 clocks
    rst = 1'b0;
    idle(3);
    chk("rst_index_out", index_out, 0);
    chk("rst_index_valid", index_valid, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b1;
    step();

    // Sky and ground with palette 3, then default band bounds
    wr(0, 3, 0);
    tick(0, 10);
    tick(1, 500);
    idle(4);
    tick(0, 299);
    tick(0, 300);
    tick(0, 427);
    tick(0, 428);
    idle(4);

    // Band unpack of words 0 and 1, back to back
    for (int i = 0; i < 6; i++) tick(i, 300);
    idle(4);

    // Scroll commits only on frame_start
    wr(1, 16'h0201, 0);
    wr(2, 4, 0);
    tick(0, 300);
    chk("pre_frame_addr", rom_addr, 0);
    idle(4);
    frame();
    tick(0, 300);
    chk("post_frame_addr", rom_addr, {7'd4, 4'd2});
    tick(1, 300);
    idle(4);
    wr(1, 16'h0300, 0);
    wr(1, 16'h0700, 1);
    tick(0, 300);
    chk("coincident_old_commit", rom_addr, {7'd4, 4'd3});
    idle(4);
    frame();
    tick(0, 300);
    chk("coincident_next_frame", rom_addr, {7'd4, 4'd7});
    idle(4);

    // Column wrap from coarse 15
    wr(1, 16'h0F00, 0);
    frame();
    for (int i = 0; i < 6; i++) tick(i, 300);
    chk("wrap_col", rom_addr[3:0], 0);
    idle(4);

    // Empty band
    wr(3, 350, 0);
    wr(4, 350, 0);
    tick(0, 349);
    tick(1, 350);
    idle(4);

    // Reset while a pixel is in flight
    tick(0, 300);
    rst = 1'b0;
    model_reset();
    idle(2);
    chk("midrst_index_out", index_out, 0);
    rst = 1'b1;
    idle(3);
    chk("midrst_no_valid", index_valid, 0);
    tick(5, 300);
    chk("midrst_addr", rom_addr, 0);
    idle(4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        tick(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1023),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(250, 480));
      end else if (r < 74) begin
        idle(3);
        wr(0, $urandom_range(0, 65535), 0);
      end else if (r < 84) begin
        wr($urandom_range(1, 7), $urandom_range(0, 65535), $urandom_range(0, 1) == 1);
      end else if (r < 89) begin
        frame();
      end else begin
        idle(1);
      end
    end
    idle(5);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
